// File: rtl/vend_ctrl.sv
// vend_ctrl: multi-product vending controller with per-unit handshaked change return.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   coin       : 00 none, 01 one unit, 10 two units, 11 cancel
//   buy, sel   : purchase request and product index
//   back_ready : change dispenser accepts one unit this cycle
//   drink      : one-cycle vend pulse; drink_id holds the last vended index
//   back_valid : one change unit offered (high for the whole refund)
//   credit     : current credit
//   coin_rej   : one-cycle pulse, coin returned unaccepted
//   err        : one-cycle pulse, buy refused
module vend_ctrl #(
    parameter int                  NPROD      = 4,
    parameter int                  CW         = 5,
    parameter int                  MAX_CREDIT = 20,
    parameter logic [NPROD*CW-1:0] PRICES     = {5'd8, 5'd6, 5'd4, 5'd3},
    localparam int                 SELW       = (NPROD > 1) ? $clog2(NPROD) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      coin,
    input  logic            buy,
    input  logic [SELW-1:0] sel,
    input  logic            back_ready,
    output logic            drink,
    output logic [SELW-1:0] drink_id,
    output logic            back_valid,
    output logic [CW-1:0]   credit,
    output logic            coin_rej,
    output logic            err
);
    typedef enum logic {IDLE, REFUND} state_t;

    localparam logic [CW:0] MAX_C = (CW+1)'(MAX_CREDIT);

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_credit, w_credit_nx;
    logic [SELW-1:0] r_drink_id, w_drink_id_nx;
    logic            r_drink, w_drink_nx;
    logic            r_coin_rej, w_coin_rej_nx;
    logic            r_err, w_err_nx;
    logic [CW:0]     w_sum;
    logic [CW-1:0]   w_price;
    logic            w_sel_ok;
    logic            w_is_coin;

    // Price lookup; indices beyond NPROD leave w_sel_ok low so the buy is refused.
    always_comb begin
        w_price  = '0;
        w_sel_ok = 1'b0;
        for (int i = 0; i < NPROD; i++) begin
            if (sel == SELW'(i)) begin
                w_price  = PRICES[i*CW +: CW];
                w_sel_ok = 1'b1;
            end
        end
    end

    // One extra bit so the ceiling compare cannot be fooled by wrap-around.
    assign w_sum     = {1'b0, r_credit} + (CW+1)'(coin);
    assign w_is_coin = coin[0] ^ coin[1];

    always_comb begin
        w_state_nx    = r_state;
        w_credit_nx   = r_credit;
        w_drink_id_nx = r_drink_id;
        w_drink_nx    = 1'b0;
        w_coin_rej_nx = 1'b0;
        w_err_nx      = 1'b0;
        if (r_state == IDLE) begin
            if (coin == 2'b11) begin
                w_state_nx = (r_credit != '0) ? REFUND : IDLE;
            end else if (w_is_coin) begin
                w_credit_nx   = (w_sum <= MAX_C) ? w_sum[CW-1:0] : r_credit;
                w_coin_rej_nx = (w_sum > MAX_C);
            end else if (buy) begin
                if (w_sel_ok && r_credit >= w_price) begin
                    w_drink_nx    = 1'b1;
                    w_drink_id_nx = sel;
                    w_credit_nx   = r_credit - w_price;
                    w_state_nx    = (r_credit != w_price) ? REFUND : IDLE;
                end else begin
                    w_err_nx = 1'b1;
                end
            end
        end else begin
            w_coin_rej_nx = w_is_coin;
            if (back_ready) begin
                w_credit_nx = r_credit - CW'(1);
                w_state_nx  = (r_credit == CW'(1)) ? IDLE : REFUND;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_credit   <= '0;
            r_drink_id <= '0;
            r_drink    <= 1'b0;
            r_coin_rej <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_credit   <= w_credit_nx;
            r_drink_id <= w_drink_id_nx;
            r_drink    <= w_drink_nx;
            r_coin_rej <= w_coin_rej_nx;
            r_err      <= w_err_nx;
        end
    end

    // back_valid comes straight off the state flop, so it drops on the final handshake edge.
    assign back_valid = (r_state == REFUND);
    assign credit     = r_credit;
    assign drink_id   = r_drink_id;
    assign drink      = r_drink;
    assign coin_rej   = r_coin_rej;
    assign err        = r_err;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: vector table, async-reset sequence and randomized model check for vend_ctrl.
module tb_vend_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       buy = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       back_ready = 1'b0;
    logic       drink, back_valid, coin_rej, err;
    logic [1:0] drink_id;
    logic [4:0] credit;

    vend_ctrl dut (
        .clk(clk), .reset(reset), .coin(coin), .buy(buy), .sel(sel),
        .back_ready(back_ready), .drink(drink), .drink_id(drink_id),
        .back_valid(back_valid), .credit(credit), .coin_rej(coin_rej), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  coin;
        logic        buy;
        logic [1:0]  sel;
        logic        br;
        logic [10:0] exp;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   failures = 0;
    int   price[4] = '{3, 4, 6, 8};

    function automatic logic [10:0] pk(int cr, int d, int id, int bv, int rej, int er);
        return {5'(cr), 1'(d), 2'(id), 1'(bv), 1'(rej), 1'(er)};
    endfunction

    task automatic v(int c, int b, int s, int br, int cr, int d, int id, int bv, int rej, int er);
        vec_t x;
        x.coin = 2'(c);
        x.buy  = 1'(b);
        x.sel  = 2'(s);
        x.br   = 1'(br);
        x.exp  = pk(cr, d, id, bv, rej, er);
        vq.push_back(x);
    endtask

    task automatic chk(string name, logic [10:0] exp);
        logic [10:0] act;
        act = {credit, drink, drink_id, back_valid, coin_rej, err};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got credit=%0d drink=%b id=%0d bv=%b rej=%b err=%b, want credit=%0d drink=%b id=%0d bv=%b rej=%b err=%b",
                     name, $time, act[10:6], act[5], act[4:3], act[2], act[1], act[0],
                     exp[10:6], exp[5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(int c, int b, int s, int br);
        coin       = 2'(c);
        buy        = 1'(b);
        sel        = 2'(s);
        back_ready = 1'(br);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m_credit, m_id, m_d, m_rej, m_err;
        bit m_ref;
        // buy after two 2-unit coins, exact price
        v(2,0,0,0, 2,0,0,0,0,0);
        v(2,0,0,0, 4,0,0,0,0,0);
        v(0,1,1,0, 0,1,1,0,0,0);
        v(0,0,0,0, 0,0,1,0,0,0);
        // buy with change, stalled dispenser
        v(2,0,0,0, 2,0,1,0,0,0);
        v(1,0,0,0, 3,0,1,0,0,0);
        v(2,0,0,0, 5,0,1,0,0,0);
        v(0,1,0,0, 2,1,0,1,0,0);
        v(0,0,0,1, 1,0,0,1,0,0);
        v(0,0,0,0, 1,0,0,1,0,0);
        v(0,0,0,1, 0,0,0,0,0,0);
        // credit ceiling
        for (int k = 1; k <= 9; k++) v(2,0,0,0, 2*k,0,0,0,0,0);
        v(1,0,0,0, 19,0,0,0,0,0);
        v(2,0,0,0, 19,0,0,0,1,0);
        v(1,0,0,0, 20,0,0,0,0,0);
        v(1,0,0,0, 20,0,0,0,1,0);
        v(3,0,0,1, 20,0,0,1,0,0);
        for (int k = 19; k >= 0; k--) v(0,0,0,1, k,0,0,(k > 0) ? 1 : 0,0,0);
        // refused buys, then cancel
        v(2,0,0,0, 2,0,0,0,0,0);
        v(2,0,0,0, 4,0,0,0,0,0);
        v(1,0,0,0, 5,0,0,0,0,0);
        v(0,1,3,0, 5,0,0,0,0,1);
        v(0,1,2,0, 5,0,0,0,0,1);
        v(3,0,0,1, 5,0,0,1,0,0);
        for (int k = 4; k >= 0; k--) v(0,0,0,1, k,0,0,(k > 0) ? 1 : 0,0,0);
        v(3,0,0,1, 0,0,0,0,0,0);
        // coin beats buy; coins and cancel during refund
        v(1,1,0,0, 1,0,0,0,0,0);
        v(2,0,0,0, 3,0,0,0,0,0);
        v(0,1,0,0, 0,1,0,0,0,0);
        v(2,0,0,0, 2,0,0,0,0,0);
        v(2,0,0,0, 4,0,0,0,0,0);
        v(2,0,0,0, 6,0,0,0,0,0);
        v(0,1,3,0, 6,0,0,0,0,1);
        v(0,1,0,0, 3,1,0,1,0,0);
        v(2,0,0,0, 3,0,0,1,1,0);
        v(1,0,0,1, 2,0,0,1,1,0);
        v(3,0,0,1, 1,0,0,1,0,0);
        v(0,1,1,0, 1,0,0,1,0,0);
        v(0,0,0,1, 0,0,0,0,0,0);
        v(0,1,0,0, 0,0,0,0,0,1);

        #12;
        chk("reset_values", pk(0,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        foreach (vq[i]) begin
            drive(vq[i].coin, vq[i].buy, vq[i].sel, vq[i].br);
            step();
            chk($sformatf("vec%0d", i), vq[i].exp);
        end

        // asynchronous reset in the middle of a refund
        drive(2,0,0,0); step();
        drive(2,0,0,0); step();
        drive(2,0,0,0); step();
        drive(0,1,0,0); step();
        chk("refund_entry", pk(3,1,0,1,0,0));
        drive(0,0,0,0); step();
        chk("refund_stall", pk(3,0,0,1,0,0));
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset", pk(0,0,0,0,0,0));
        drive(0,0,0,1); step(); step();
        chk("reset_hold", pk(0,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_reset_idle", pk(0,0,0,0,0,0));

        // randomized run against a rule-level model
        m_credit = 0; m_id = 0; m_ref = 0;
        for (int n = 0; n < 3000; n++) begin
            int r, c, b, s, br;
            r  = int'($urandom_range(0, 9));
            c  = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            b  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            s  = int'($urandom_range(0, 3));
            br = int'($urandom_range(0, 1));
            drive(c, b, s, br);
            m_d = 0; m_rej = 0; m_err = 0;
            if (m_ref) begin
                if (c == 1 || c == 2) m_rej = 1;
                if (br == 1) begin
                    m_credit = m_credit - 1;
                    if (m_credit == 0) m_ref = 0;
                end
            end else if (c == 3) begin
                if (m_credit > 0) m_ref = 1;
            end else if (c != 0) begin
                if (m_credit + c <= 20) m_credit = m_credit + c;
                else m_rej = 1;
            end else if (b == 1) begin
                if (m_credit >= price[s]) begin
                    m_d = 1;
                    m_id = s;
                    m_credit = m_credit - price[s];
                    m_ref = (m_credit > 0);
                end else begin
                    m_err = 1;
                end
            end
            step();
            chk($sformatf("rand%0d", n), pk(m_credit, m_d, m_id, m_ref ? 1 : 0, m_rej, m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
